// File: rtl/video_raster_gen.sv
// video_raster_gen: pixel/line counter chain producing sync, blanking and a centred
// character window with glyph counters and a multiplier-free character-RAM address.
module video_raster_gen #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_LEN   = 96,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_LEN   = 2,
    parameter int CE_DIV       = 2,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 8,
    parameter int COLS0        = 64,
    parameter int ROWS0        = 32,
    parameter int VREP0        = 1,
    parameter int COLS1        = 48,
    parameter int ROWS1        = 16,
    parameter int VREP1        = 2,
    parameter int SYNC_NEG     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    output logic        ce_pix,
    output logic        hs,
    output logic        vs,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic        in_window,
    output logic [6:0]  col,
    output logic [5:0]  row,
    output logic [2:0]  px,
    output logic [2:0]  py,
    output logic [10:0] char_addr,
    output logic        frame_start,
    output logic        mode_active
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int HX  = HW + 1;
    localparam int VX  = VW + 1;
    localparam int DW  = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
    localparam int RW  = $clog2((VREP0 > VREP1 ? VREP0 : VREP1) + 1);
    localparam int WW0 = COLS0 * CHAR_W;
    localparam int WH0 = ROWS0 * CHAR_H * VREP0;
    localparam int WW1 = COLS1 * CHAR_W;
    localparam int WH1 = ROWS1 * CHAR_H * VREP1;

    localparam logic [HX-1:0] L0    = HX'((H_ACTIVE - WW0) / 2);
    localparam logic [HX-1:0] R0    = HX'((H_ACTIVE - WW0) / 2 + WW0);
    localparam logic [HX-1:0] L1    = HX'((H_ACTIVE - WW1) / 2);
    localparam logic [HX-1:0] R1    = HX'((H_ACTIVE - WW1) / 2 + WW1);
    localparam logic [VX-1:0] T0    = VX'((V_ACTIVE - WH0) / 2);
    localparam logic [VX-1:0] B0    = VX'((V_ACTIVE - WH0) / 2 + WH0);
    localparam logic [VX-1:0] T1    = VX'((V_ACTIVE - WH1) / 2);
    localparam logic [VX-1:0] B1    = VX'((V_ACTIVE - WH1) / 2 + WH1);
    localparam logic [HX-1:0] H_ACT = HX'(H_ACTIVE);
    localparam logic [HX-1:0] HS_B  = HX'(H_SYNC_START);
    localparam logic [HX-1:0] HS_E  = HX'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VX-1:0] V_ACT = VX'(V_ACTIVE);
    localparam logic [VX-1:0] VS_B  = VX'(V_SYNC_START);
    localparam logic [VX-1:0] VS_E  = VX'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CE_DIV - 1);
    localparam logic [RW-1:0] P0_LAST = RW'(VREP0 - 1);
    localparam logic [RW-1:0] P1_LAST = RW'(VREP1 - 1);
    localparam logic [2:0]    PX_LAST = 3'(CHAR_W - 1);
    localparam logic [2:0]    PY_LAST = 3'(CHAR_H - 1);
    localparam logic [10:0]   C0 = 11'(COLS0);
    localparam logic [10:0]   C1 = 11'(COLS1);
    localparam logic          SN = SYNC_NEG != 0;

    if (WW0 > H_ACTIVE || WW1 > H_ACTIVE || WH0 > V_ACTIVE || WH1 > V_ACTIVE ||
        CHAR_W > 8 || CHAR_H > 8 || CE_DIV < 1) begin : g_bad_geometry
        $error("video_raster_gen: character window does not fit the active area");
    end

    logic [DW-1:0] r_div;
    logic          r_run;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_mode, r_hs, r_vs, r_hb, r_vb, r_de, r_in, r_fs;
    logic [2:0]    r_px, r_py;
    logic [6:0]    r_col;
    logic [5:0]    r_row;
    logic [RW-1:0] r_rep;
    logic [10:0]   r_rb, r_addr;

    logic          w_ce, w_hwrap, w_vwrap, w_mode_n;
    logic [HW-1:0] w_hn;
    logic [VW-1:0] w_vn;
    logic [HX-1:0] w_hx, w_left, w_right;
    logic [VX-1:0] w_vx, w_top, w_bot;
    logic [RW-1:0] w_rep_last, w_rep_n;
    logic [10:0]   w_cols, w_rb_n;
    logic          w_hin, w_vin, w_hedge, w_vtop, w_vstep, w_rowstep;
    logic          w_pxw, w_pyw, w_repw;
    logic [2:0]    w_px_n, w_py_n;
    logic [6:0]    w_col_n;
    logic [5:0]    w_row_n;

    assign w_ce    = r_div == D_LAST;
    assign ce_pix  = w_ce & ~reset;

    // The first pixel enable after reset presents (0,0) instead of advancing past it.
    assign w_hwrap  = r_run & (r_h == H_LAST);
    assign w_vwrap  = w_hwrap & (r_v == V_LAST);
    assign w_hn     = (!r_run || w_hwrap) ? '0 : r_h + 1'b1;
    assign w_vn     = (!r_run || w_vwrap) ? '0 : w_hwrap ? r_v + 1'b1 : r_v;
    assign w_mode_n = w_vwrap ? mode : r_mode;
    assign w_hx     = {1'b0, w_hn};
    assign w_vx     = {1'b0, w_vn};

    assign w_left     = w_mode_n ? L1 : L0;
    assign w_right    = w_mode_n ? R1 : R0;
    assign w_top      = w_mode_n ? T1 : T0;
    assign w_bot      = w_mode_n ? B1 : B0;
    assign w_rep_last = w_mode_n ? P1_LAST : P0_LAST;
    assign w_cols     = w_mode_n ? C1 : C0;

    assign w_hin   = (w_hx >= w_left) && (w_hx < w_right);
    assign w_vin   = (w_vx >= w_top) && (w_vx < w_bot);
    assign w_hedge = w_hx == w_left;
    // Vertical glyph state steps once per line, at the window's left edge.
    assign w_vtop    = w_hedge && (w_vx == w_top);
    assign w_vstep   = w_hedge && w_vin && !w_vtop;
    assign w_pxw     = r_px == PX_LAST;
    assign w_pyw     = r_py == PY_LAST;
    assign w_repw    = r_rep == w_rep_last;
    assign w_rowstep = w_vstep & w_repw & w_pyw;

    assign w_px_n  = w_hedge ? '0 : !w_hin ? r_px : w_pxw ? '0 : r_px + 1'b1;
    assign w_col_n = w_hedge ? '0 : (w_hin & w_pxw) ? r_col + 1'b1 : r_col;
    assign w_rep_n = w_vtop ? '0 : !w_vstep ? r_rep : w_repw ? '0 : r_rep + 1'b1;
    assign w_py_n  = w_vtop ? '0 : !(w_vstep & w_repw) ? r_py : w_pyw ? '0 : r_py + 1'b1;
    assign w_row_n = w_vtop ? '0 : w_rowstep ? r_row + 1'b1 : r_row;
    assign w_rb_n  = w_vtop ? '0 : w_rowstep ? r_rb + w_cols : r_rb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_run  <= 1'b0;
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= 1'b0;
            r_hs   <= SN;
            r_vs   <= SN;
            r_hb   <= 1'b1;
            r_vb   <= 1'b1;
            r_de   <= 1'b0;
            r_in   <= 1'b0;
            r_fs   <= 1'b0;
            r_px   <= '0;
            r_col  <= '0;
            r_py   <= '0;
            r_row  <= '0;
            r_rep  <= '0;
            r_rb   <= '0;
            r_addr <= '0;
        end else begin
            r_div <= w_ce ? '0 : r_div + 1'b1;
            r_fs  <= w_ce && (w_hn == '0) && (w_vn == '0);
            if (w_ce) begin
                r_run  <= 1'b1;
                r_h    <= w_hn;
                r_v    <= w_vn;
                r_mode <= w_mode_n;
                r_hs   <= SN ^ ((w_hx >= HS_B) && (w_hx < HS_E));
                r_vs   <= SN ^ ((w_vx >= VS_B) && (w_vx < VS_E));
                r_hb   <= w_hx >= H_ACT;
                r_vb   <= w_vx >= V_ACT;
                r_de   <= (w_hx < H_ACT) && (w_vx < V_ACT);
                r_in   <= w_hin & w_vin;
                r_px   <= w_px_n;
                r_col  <= w_col_n;
                r_py   <= w_py_n;
                r_row  <= w_row_n;
                r_rep  <= w_rep_n;
                r_rb   <= w_rb_n;
                r_addr <= w_rb_n + {4'b0, w_col_n};
            end
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign hblank      = r_hb;
    assign vblank      = r_vb;
    assign de          = r_de;
    assign in_window   = r_in;
    assign col         = r_col;
    assign row         = r_row;
    assign px          = r_px;
    assign py          = r_py;
    assign char_addr   = r_addr;
    assign frame_start = r_fs;
    assign mode_active = r_mode;
endmodule
